fat32_volume_id_parser: RTL and testbench

// - Consumes the 512-byte Volume ID sector streamed by sd_card_controller during the FAT32 controller's

---
 rtl/fat32_volume_id_parser_pkg.sv | 36 +++
 rtl/fat32_volume_id_parser_if.sv | 28 ++
 rtl/fat32_le_field_capture.sv | 35 +++
 rtl/fat32_volume_id_parser.sv | 117 +++++++++++
 tb/tb_fat32_volume_id_parser.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/fat32_volume_id_parser_pkg.sv
// Shared definitions for the FAT32 Volume ID parser: BPB offsets, error codes, FSM encoding.
package fat32_pkg;

  localparam int OFS_BYTS_PER_SEC = 11;
  localparam int OFS_SEC_PER_CLUS = 13;
  localparam int OFS_RSVD_SEC_CNT = 14;
  localparam int OFS_NUM_FATS     = 16;
  localparam int OFS_FAT_SZ32     = 36;
  localparam int OFS_ROOT_CLUS    = 44;
  localparam int OFS_SIG0         = 510;
  localparam int OFS_SIG1         = 511;

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_SIG   = 3'd1;
  localparam logic [2:0] ERR_BYTS  = 3'd2;
  localparam logic [2:0] ERR_NFATS = 3'd3;
  localparam logic [2:0] ERR_SHORT = 3'd4;
  localparam logic [2:0] ERR_SPC   = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_COLLECT  = 3'd1,
    ST_CHECK    = 3'd2,
    ST_CALC_FAT = 3'd3,
    ST_CALC_CLU = 3'd4,
    ST_DONE     = 3'd5
  } state_e;

  // True when the byte counter addresses one of the nb bytes starting at ofs.
  function automatic logic in_window(input logic [9:0] cnt, input int ofs, input int nb);
    int c;
    c = int'(cnt);
    return (c >= ofs) && (c < ofs + nb);
  endfunction

endpackage

// File: rtl/fat32_volume_id_parser_if.sv
// Byte stream from the SD controller plus control/result signals toward the FAT32 controller.
interface fat32_volume_id_parser_if;
  logic        start;
  logic [31:0] partition_lba_begin;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        block_done;
  logic        busy;
  logic        done;
  logic        error;
  logic [2:0]  error_code;
  logic [7:0]  sectors_per_cluster;
  logic [31:0] root_dir_first_cluster;
  logic [31:0] fat_begin_lba;
  logic [31:0] cluster_begin_lba;

  modport master (
    output start, partition_lba_begin, byte_in, byte_valid, block_done,
    input  busy, done, error, error_code, sectors_per_cluster,
           root_dir_first_cluster, fat_begin_lba, cluster_begin_lba
  );

  modport slave (
    input  start, partition_lba_begin, byte_in, byte_valid, block_done,
    output busy, done, error, error_code, sectors_per_cluster,
           root_dir_first_cluster, fat_begin_lba, cluster_begin_lba
  );
endinterface

// File: rtl/fat32_le_field_capture.sv
// Captures one little-endian BPB field from the byte stream at a fixed sector offset.
module fat32_le_field_capture
  import fat32_pkg::*;
#(
  parameter int OFFSET      = 0,
  parameter int WIDTH_BYTES = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       byte_en,
  input  logic [9:0]                 cnt,
  input  logic [7:0]                 byte_in,
  output logic [8*WIDTH_BYTES-1:0]   field
);
  logic hit;
  assign hit = byte_en && in_window(cnt, OFFSET, WIDTH_BYTES);

  generate
    if (WIDTH_BYTES == 1) begin : g_one
      always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n)   field <= '0;
        else if (clr) field <= '0;
        else if (hit) field <= byte_in;
      end
    end else begin : g_multi
      // LSB arrives first, so shifting in from the top leaves it at the bottom after the last byte.
      always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n)   field <= '0;
        else if (clr) field <= '0;
        else if (hit) field <= {byte_in, field[8*WIDTH_BYTES-1:8]};
      end
    end
  endgenerate
endmodule

// File: rtl/fat32_volume_id_parser.sv
// Parses the FAT32 Volume ID sector, validates it and derives FAT / cluster-heap start LBAs.
module fat32_volume_id_parser
  import fat32_pkg::*;
#(
  parameter int BLOCK_BYTES          = 512,
  parameter int EXP_BYTES_PER_SECTOR = 512,
  parameter int EXP_NUM_FATS         = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  fat32_volume_id_parser_if.slave bus
);
  localparam logic [9:0]  BLK      = 10'(BLOCK_BYTES);
  localparam logic [15:0] EXP_BYTS = 16'(EXP_BYTES_PER_SECTOR);
  localparam logic [7:0]  EXP_NF   = 8'(EXP_NUM_FATS);

  state_e      state_q, state_d;
  logic [9:0]  cnt_q;
  logic [31:0] part_q, fat_q, fat_mul;
  logic [2:0]  err_q, chk_code;
  logic        start_ok, byte_en;
  logic [15:0] byts, rsvd;
  logic [7:0]  spc, nfats, sig0, sig1;
  logic [31:0] fatsz, root;

  assign start_ok = bus.start && (state_q == ST_IDLE);
  assign byte_en  = bus.byte_valid && (state_q == ST_COLLECT) && (cnt_q < BLK);

  fat32_le_field_capture #(.OFFSET(OFS_BYTS_PER_SEC), .WIDTH_BYTES(2)) u_byts (
    .clk, .rst_n, .clr(start_ok), .byte_en, .cnt(cnt_q), .byte_in(bus.byte_in), .field(byts));
  fat32_le_field_capture #(.OFFSET(OFS_SEC_PER_CLUS), .WIDTH_BYTES(1)) u_spc (
    .clk, .rst_n, .clr(start_ok), .byte_en, .cnt(cnt_q), .byte_in(bus.byte_in), .field(spc));
  fat32_le_field_capture #(.OFFSET(OFS_RSVD_SEC_CNT), .WIDTH_BYTES(2)) u_rsvd (
    .clk, .rst_n, .clr(start_ok), .byte_en, .cnt(cnt_q), .byte_in(bus.byte_in), .field(rsvd));
  fat32_le_field_capture #(.OFFSET(OFS_NUM_FATS), .WIDTH_BYTES(1)) u_nfats (
    .clk, .rst_n, .clr(start_ok), .byte_en, .cnt(cnt_q), .byte_in(bus.byte_in), .field(nfats));
  fat32_le_field_capture #(.OFFSET(OFS_FAT_SZ32), .WIDTH_BYTES(4)) u_fatsz (
    .clk, .rst_n, .clr(start_ok), .byte_en, .cnt(cnt_q), .byte_in(bus.byte_in), .field(fatsz));
  fat32_le_field_capture #(.OFFSET(OFS_ROOT_CLUS), .WIDTH_BYTES(4)) u_root (
    .clk, .rst_n, .clr(start_ok), .byte_en, .cnt(cnt_q), .byte_in(bus.byte_in), .field(root));
  fat32_le_field_capture #(.OFFSET(OFS_SIG0), .WIDTH_BYTES(1)) u_sig0 (
    .clk, .rst_n, .clr(start_ok), .byte_en, .cnt(cnt_q), .byte_in(bus.byte_in), .field(sig0));
  fat32_le_field_capture #(.OFFSET(OFS_SIG1), .WIDTH_BYTES(1)) u_sig1 (
    .clk, .rst_n, .clr(start_ok), .byte_en, .cnt(cnt_q), .byte_in(bus.byte_in), .field(sig1));

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:     if (bus.start) state_d = ST_COLLECT;
      ST_COLLECT:  if (bus.block_done) state_d = ST_CHECK;
      ST_CHECK:    state_d = ST_CALC_FAT;
      ST_CALC_FAT: state_d = ST_CALC_CLU;
      ST_CALC_CLU: state_d = ST_DONE;
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // A short block never delivered bytes 510/511, so its signature is not judged; it reports as short.
  always_comb begin
    chk_code = ERR_NONE;
    if ((cnt_q == BLK) && ((sig0 != 8'h55) || (sig1 != 8'hAA))) chk_code = ERR_SIG;
    else if (byts != EXP_BYTS)                                   chk_code = ERR_BYTS;
    else if (nfats != EXP_NF)                                    chk_code = ERR_NFATS;
    else if (cnt_q < BLK)                                        chk_code = ERR_SHORT;
    else if ((spc == 8'd0) || ((spc & (spc - 8'd1)) != 8'd0))    chk_code = ERR_SPC;
  end

  // NumFATs never exceeds 2 on a valid volume, so two shift-add terms cover the product.
  assign fat_mul = (nfats[0] ? fatsz : 32'd0) + (nfats[1] ? {fatsz[30:0], 1'b0} : 32'd0);

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      part_q <= '0;
      err_q  <= ERR_NONE;
      fat_q  <= '0;
    end else begin
      if (start_ok)     cnt_q <= '0;
      else if (byte_en) cnt_q <= cnt_q + 10'd1;
      if (start_ok)                 part_q <= bus.partition_lba_begin;
      if (state_q == ST_CHECK)      err_q  <= chk_code;
      if (state_q == ST_CALC_FAT)   fat_q  <= part_q + {16'd0, rsvd};
    end
  end

  assign bus.busy = (state_q == ST_COLLECT) || (state_q == ST_CHECK) ||
                    (state_q == ST_CALC_FAT) || (state_q == ST_CALC_CLU);
  assign bus.done = (state_q == ST_DONE);

  // Results publish on the edge that raises done and hold until the next accepted start.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.error                  <= 1'b0;
      bus.error_code             <= ERR_NONE;
      bus.sectors_per_cluster    <= '0;
      bus.root_dir_first_cluster <= '0;
      bus.fat_begin_lba          <= '0;
      bus.cluster_begin_lba      <= '0;
    end else if (start_ok) begin
      bus.error      <= 1'b0;
      bus.error_code <= ERR_NONE;
    end else if (state_q == ST_CALC_CLU) begin
      bus.error                  <= (err_q != ERR_NONE);
      bus.error_code             <= err_q;
      bus.sectors_per_cluster    <= spc;
      bus.root_dir_first_cluster <= root;
      bus.fat_begin_lba          <= fat_q;
      bus.cluster_begin_lba      <= fat_q + fat_mul;
    end
  end
endmodule

// File: tb/tb_fat32_volume_id_parser.sv
// Directed + randomized bench for fat32_volume_id_parser against a sector-level reference model.
module tb_fat32_volume_id_parser;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fat32_volume_id_parser_if bus ();
  fat32_volume_id_parser dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int          tests = 0;
  int          fails = 0;
  logic [7:0]  sec [512];
  logic [31:0] part;
  logic [2:0]  e_code = 3'd0;
  logic [7:0]  e_spc = 8'd0;
  logic [31:0] e_root = 32'd0, e_fat = 32'd0, e_clu = 32'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_fields(input logic [15:0] byts, input logic [7:0] spc, input logic [15:0] rsvd,
                            input logic [7:0] nf, input logic [31:0] fatsz, input logic [31:0] root,
                            input logic [15:0] sig);
    for (int i = 0; i < 512; i++) sec[i] = 8'($urandom);
    sec[11] = byts[7:0];  sec[12] = byts[15:8];
    sec[13] = spc;
    sec[14] = rsvd[7:0];  sec[15] = rsvd[15:8];
    sec[16] = nf;
    for (int i = 0; i < 4; i++) begin
      sec[36+i] = fatsz[8*i +: 8];
      sec[44+i] = root[8*i +: 8];
    end
    sec[510] = sig[15:8]; sec[511] = sig[7:0];
  endtask

  // Bytes the parser never received read as zero (fields clear on start).
  function automatic logic [7:0] rx(input int i, input int n);
    return (i < n) ? sec[i] : 8'h00;
  endfunction

  task automatic model(input int n_in);
    int n, byts, spc, rsvd, nf;
    longint fatsz, root;
    n     = (n_in > 512) ? 512 : n_in;
    byts  = rx(11, n) + 256 * rx(12, n);
    spc   = rx(13, n);
    rsvd  = rx(14, n) + 256 * rx(15, n);
    nf    = rx(16, n);
    fatsz = 0; root = 0;
    for (int k = 3; k >= 0; k--) begin
      fatsz = fatsz * 256 + rx(36 + k, n);
      root  = root * 256 + rx(44 + k, n);
    end
    if (n == 512 && (rx(510, n) != 8'h55 || rx(511, n) != 8'hAA)) e_code = 3'd1;
    else if (byts != 512)               e_code = 3'd2;
    else if (nf != 2)                   e_code = 3'd3;
    else if (n < 512)                   e_code = 3'd4;
    else if ($countones(spc) != 1)      e_code = 3'd5;
    else                                e_code = 3'd0;
    e_spc  = 8'(spc);
    e_root = 32'(root);
    e_fat  = 32'(longint'(part) + rsvd);
    e_clu  = 32'(longint'(e_fat) + longint'(nf) * fatsz);
  endtask

  task automatic run_block(input int n, input bit coinc, input bit start_mid, input bit start_at_done);
    int k;
    @(posedge clk);
    bus.start = 1'b1;
    bus.partition_lba_begin = part;
    @(posedge clk);
    bus.start = 1'b0;
    bus.partition_lba_begin = $urandom;
    check("busy_after_start", 32'(bus.busy), 32'd1);
    check("error_clr_on_start", 32'(bus.error), 32'd0);
    check("code_clr_on_start", 32'(bus.error_code), 32'd0);
    check("spc_held_on_start", 32'(bus.sectors_per_cluster), 32'(e_spc));
    check("clu_held_on_start", bus.cluster_begin_lba, e_clu);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.byte_valid = 1'b0; bus.block_done = 1'b0; bus.start = 1'b0;
        @(posedge clk);
      end
      bus.byte_valid = 1'b1;
      bus.byte_in    = (i < 512) ? sec[i] : 8'($urandom);
      bus.start      = start_mid && (i == 100);
      bus.block_done = coinc && (i == n - 1);
      @(posedge clk);
    end
    bus.byte_valid = 1'b0; bus.start = 1'b0; bus.block_done = 1'b0;
    if (!coinc) begin
      bus.block_done = 1'b1;
      @(posedge clk);
      bus.block_done = 1'b0;
    end
    model(n);
    k = 0;
    do begin
      @(negedge clk); #1;
      k++;
    end while (!bus.done && k < 8);
    check("done_latency", 32'(k), 32'd3);
    check("busy_low_at_done", 32'(bus.busy), 32'd0);
    check("error", 32'(bus.error), 32'(e_code != 3'd0));
    check("error_code", 32'(bus.error_code), 32'(e_code));
    check("sectors_per_cluster", 32'(bus.sectors_per_cluster), 32'(e_spc));
    check("root_dir_first_cluster", bus.root_dir_first_cluster, e_root);
    check("fat_begin_lba", bus.fat_begin_lba, e_fat);
    check("cluster_begin_lba", bus.cluster_begin_lba, e_clu);
    if (start_at_done) bus.start = 1'b1;
    @(negedge clk); #1;
    check("done_one_cycle", 32'(bus.done), 32'd0);
    if (start_at_done) begin
      check("start_at_done_ignored", 32'(bus.busy), 32'd0);
      bus.start = 1'b0;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.partition_lba_begin = '0; bus.byte_in = '0;
    bus.byte_valid = 1'b0; bus.block_done = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_error", 32'(bus.error), 32'd0);
    check("rst_code", 32'(bus.error_code), 32'd0);
    check("rst_spc", 32'(bus.sectors_per_cluster), 32'd0);
    check("rst_root", bus.root_dir_first_cluster, 32'd0);
    check("rst_fat", bus.fat_begin_lba, 32'd0);
    check("rst_clu", bus.cluster_begin_lba, 32'd0);
    @(posedge clk);
    rst_n = 1'b1;

    // Golden sector, with a start pulse mid-block that must be ignored
    set_fields(16'd512, 8'd8, 16'd32, 8'd2, 32'h3C1, 32'd2, 16'h55AA);
    part = 32'h800;
    run_block(512, 1'b0, 1'b1, 1'b0);
    check("golden_fat_const", bus.fat_begin_lba, 32'h820);
    check("golden_code_const", 32'(bus.error_code), 32'd0);

    // Bad signature: error 1, raw fields still presented
    sec[511] = 8'hAB;
    run_block(512, 1'b0, 1'b0, 1'b0);
    check("sig_code_const", 32'(bus.error_code), 32'd1);
    check("sig_spc_const", 32'(bus.sectors_per_cluster), 32'd8);

    // Byts and NumFATs both wrong: lower code wins; also start coincident with done
    set_fields(16'h0400, 8'd8, 16'd32, 8'd1, 32'h3C1, 32'd2, 16'h55AA);
    run_block(512, 1'b0, 1'b0, 1'b1);
    check("prio_code_const", 32'(bus.error_code), 32'd2);

    // Short block, then block_done on the 512th byte, then an overlong block
    set_fields(16'd512, 8'd8, 16'd32, 8'd2, 32'h3C1, 32'd2, 16'h55AA);
    run_block(300, 1'b0, 1'b0, 1'b0);
    check("short_code_const", 32'(bus.error_code), 32'd4);
    run_block(512, 1'b1, 1'b0, 1'b0);
    check("coinc_code_const", 32'(bus.error_code), 32'd0);
    run_block(515, 1'b0, 1'b0, 1'b0);

    // LBA wrap and non-power-of-two SecPerClus
    set_fields(16'd512, 8'd6, 16'hFFFF, 8'd2, 32'h3C1, 32'd2, 16'h55AA);
    part = 32'hFFFF_FFF0;
    run_block(512, 1'b0, 1'b0, 1'b0);
    check("wrap_fat_const", bus.fat_begin_lba, 32'h0000_FFEF);
    check("spc_code_const", 32'(bus.error_code), 32'd5);

    // Reset mid-block: no done, outputs back to reset values, then a clean golden run
    set_fields(16'd512, 8'd8, 16'd32, 8'd2, 32'h3C1, 32'd2, 16'h55AA);
    part = 32'h800;
    @(posedge clk);
    bus.start = 1'b1; bus.partition_lba_begin = part;
    @(posedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      bus.byte_valid = 1'b1; bus.byte_in = sec[i];
      @(posedge clk);
    end
    rst_n = 1'b0;
    bus.block_done = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      check("abort_no_done", 32'(bus.done), 32'd0);
      check("abort_busy", 32'(bus.busy), 32'd0);
    end
    check("abort_fat", bus.fat_begin_lba, 32'd0);
    check("abort_code", 32'(bus.error_code), 32'd0);
    @(posedge clk);
    bus.byte_valid = 1'b0; bus.block_done = 1'b0;
    rst_n = 1'b1;
    e_spc = 8'd0; e_root = 32'd0; e_fat = 32'd0; e_clu = 32'd0; e_code = 3'd0;
    run_block(512, 1'b0, 1'b0, 1'b0);

    // Randomized sectors
    for (int r = 0; r < 8; r++) begin
      int n;
      logic [7:0]  spc, nf;
      logic [15:0] byts, sig;
      spc  = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'(1 << $urandom_range(0, 7));
      byts = ($urandom_range(0, 5) == 0) ? (16'h0200 ^ 16'($urandom_range(1, 255))) : 16'h0200;
      nf   = ($urandom_range(0, 5) == 0) ? 8'd1 : 8'd2;
      sig  = ($urandom_range(0, 5) == 0) ? 16'h55AB : 16'h55AA;
      if ($urandom_range(0, 5) == 0)      n = int'($urandom_range(20, 511));
      else if ($urandom_range(0, 5) == 0) n = int'($urandom_range(513, 520));
      else                                n = 512;
      set_fields(byts, spc, 16'($urandom), nf, $urandom, $urandom, sig);
      part = $urandom;
      run_block(n, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
